// File: rtl/u_d_step_encoder.sv
// Delta-step encoder: walks a shadow of the downstream up/down counter toward an
// accepted target, one u_d/en step per divider tick.
module u_d_step_encoder #(
   parameter int unsigned      WIDTH     = 16,
   parameter logic [WIDTH-1:0] RESET_VAL = {1'b1, {(WIDTH-1){1'b0}}},
   parameter int unsigned      STEP_DIV  = 1
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic [WIDTH-1:0] target,
   input  logic             target_valid,
   output logic             target_ready,
   input  logic             en_in,
   output logic             u_d,
   output logic             en,
   output logic [WIDTH-1:0] shadow,
   output logic             settled
);

   localparam int unsigned DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_TRACK   = 2'd1,
      ST_SETTLED = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] tgt_q, tgt_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             en_q, en_d;
   logic             u_d_q, u_d_d;
   logic             settled_q, settled_d;
   logic             ready_q, ready_d;

   logic             accept;
   logic             tick;
   logic             step_up;
   logic [WIDTH-1:0] stepped;

   // State and registered outputs; reset realigns with the counter midpoint
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q   <= ST_IDLE;
         tgt_q     <= RESET_VAL;
         shadow_q  <= RESET_VAL;
         div_q     <= '0;
         en_q      <= 1'b0;
         u_d_q     <= 1'b0;
         settled_q <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         tgt_q     <= tgt_d;
         shadow_q  <= shadow_d;
         div_q     <= div_d;
         en_q      <= en_d;
         u_d_q     <= u_d_d;
         settled_q <= settled_d;
         ready_q   <= ready_d;
      end
   end

   // Next-state: accept targets when idle/settled, step toward target on ticks
   always_comb begin
      state_d   = state_q;
      tgt_d     = tgt_q;
      shadow_d  = shadow_q;
      div_d     = div_q;
      en_d      = 1'b0;
      u_d_d     = u_d_q;
      settled_d = settled_q;
      accept    = target_valid & ready_q;
      tick      = (div_q == DIV_LAST);
      step_up   = (tgt_q > shadow_q);
      stepped   = shadow_q;

      case (state_q)
         ST_IDLE, ST_SETTLED: begin
            if (accept) begin
               tgt_d = target;
               div_d = '0;
               if (target == shadow_q) begin
                  state_d   = ST_SETTLED;
                  settled_d = 1'b1;
               end else begin
                  state_d   = ST_TRACK;
                  settled_d = 1'b0;
               end
            end
         end
         ST_TRACK: begin
            if (en_in) begin
               if (tick) begin
                  div_d = '0;
                  if (shadow_q != tgt_q) begin
                     // Stepping only toward an in-range target can never wrap
                     stepped  = step_up ? (shadow_q + WIDTH'(1)) : (shadow_q - WIDTH'(1));
                     shadow_d = stepped;
                     en_d     = 1'b1;
                     u_d_d    = step_up;
                     if (stepped == tgt_q) begin
                        state_d   = ST_SETTLED;
                        settled_d = 1'b1;
                     end
                  end
               end else begin
                  div_d = div_q + DIV_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      ready_d = (state_d != ST_TRACK);
   end

   assign target_ready = ready_q;
   assign u_d          = u_d_q;
   assign en           = en_q;
   assign shadow       = shadow_q;
   assign settled      = settled_q;

endmodule

// File: tb/tb_u_d_step_encoder.sv
// Bench for u_d_step_encoder: two instances (STEP_DIV 1 and 4) with counter models.
module tb_u_d_step_encoder;

   logic        clk = 1'b0;
   logic        rstb;
   logic [15:0] tgt_i [2];
   logic        vld   [2];
   logic        eni   [2];
   logic        rdy   [2];
   logic        ud    [2];
   logic        en_o  [2];
   logic [15:0] shd   [2];
   logic        stl   [2];
   logic [15:0] cnt   [2];
   logic [15:0] mdl   [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   u_d_step_encoder #(.WIDTH(16), .STEP_DIV(1)) dut1 (
      .clk(clk), .rstb(rstb), .target(tgt_i[0]), .target_valid(vld[0]),
      .target_ready(rdy[0]), .en_in(eni[0]), .u_d(ud[0]), .en(en_o[0]),
      .shadow(shd[0]), .settled(stl[0]));

   u_d_step_encoder #(.WIDTH(16), .STEP_DIV(4)) dut4 (
      .clk(clk), .rstb(rstb), .target(tgt_i[1]), .target_valid(vld[1]),
      .target_ready(rdy[1]), .en_in(eni[1]), .u_d(ud[1]), .en(en_o[1]),
      .shadow(shd[1]), .settled(stl[1]));

   // Downstream up/down counters driven by each encoder
   always @(posedge clk or negedge rstb) begin
      for (int k = 0; k < 2; k++) begin
         if (!rstb) cnt[k] <= 16'h8000;
         else if (en_o[k]) cnt[k] <= ud[k] ? cnt[k] + 16'd1 : cnt[k] - 16'd1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstb = 1'b0;
      repeat (3) step_cycle();
      for (int k = 0; k < 2; k++) begin
         chk("rst_shadow", 32'(shd[k]), 32'h8000);
         chk("rst_en", 32'(en_o[k]), 32'd0);
         chk("rst_settled", 32'(stl[k]), 32'd0);
         chk("rst_ready", 32'(rdy[k]), 32'd1);
         chk("rst_counter", 32'(cnt[k]), 32'h8000);
         mdl[k] = 16'h8000;
      end
      rstb = 1'b1;
      step_cycle();
   endtask

   // Applies one target; mode 0: en_in high, 1: random en_in, 2: en_in low at offsets 5,6
   task automatic run_target(input int k, input logic [15:0] t, input int mode, input bit hold,
                             output int pulses, output int settle_at);
      int d, n, need, high, c, budget;
      bit up, en_was, exp_en;
      logic [15:0] start;
      d      = (k == 0) ? 1 : 4;
      start  = mdl[k];
      up     = (t > start);
      n      = up ? int'(t) - int'(start) : int'(start) - int'(t);
      need   = n * d;
      pulses = 0;
      settle_at = -1;
      high   = 0;
      chk("ready_before", 32'(rdy[k]), 32'd1);
      tgt_i[k] = t;
      vld[k]   = 1'b1;
      eni[k]   = 1'b1;
      step_cycle();
      if (hold) tgt_i[k] = t ^ 16'h0F0F;
      else vld[k] = 1'b0;
      chk("accept_settled", 32'(stl[k]), 32'(n == 0));
      chk("accept_en", 32'(en_o[k]), 32'd0);
      chk("accept_ready", 32'(rdy[k]), 32'(n == 0));
      if (n == 0) begin
         settle_at = 0;
         vld[k] = 1'b0;
         repeat (3) begin
            step_cycle();
            chk("equal_no_en", 32'(en_o[k]), 32'd0);
            chk("equal_settled", 32'(stl[k]), 32'd1);
            chk("equal_shadow", 32'(shd[k]), 32'(t));
         end
      end else begin
         c = 0;
         budget = 2 * need + 64;
         while (high < need && c < budget) begin
            if (mode == 1)      en_was = ($urandom_range(0, 3) != 0);
            else if (mode == 2) en_was = !((c + 1 == 5) || (c + 1 == 6));
            else                en_was = 1'b1;
            eni[k] = en_was;
            step_cycle();
            c++;
            if (en_was) high++;
            exp_en = en_was && (high % d == 0);
            chk("step_en", 32'(en_o[k]), 32'(exp_en));
            if (en_o[k]) begin
               pulses++;
               chk("step_dir", 32'(ud[k]), 32'(up));
            end
            chk("track_settled", 32'(stl[k]), 32'(high == need));
            chk("track_ready", 32'(rdy[k]), 32'(high == need));
         end
         if (high < need) begin
            checks++;
            errors++;
            $display("FAIL settle_timeout: high %0d expected %0d", high, need);
         end else begin
            settle_at = c;
         end
         vld[k] = 1'b0;
         eni[k] = 1'b1;
         chk("settle_shadow", 32'(shd[k]), 32'(t));
         chk("pulse_count", 32'(pulses), 32'(n));
      end
      step_cycle();
      chk("counter_final", 32'(cnt[k]), 32'(t));
      chk("idle_en", 32'(en_o[k]), 32'd0);
      if (n != 0) chk("ud_hold", 32'(ud[k]), 32'(up));
      mdl[k] = t;
   endtask

   typedef struct {
      int          k;
      logic [15:0] tgt;
      int          mode;
      bit          hold;
      int          exp_pulses;
      int          exp_settle;
   } vec_t;

   initial begin
      vec_t vecs[7];
      int p, s, n, off, v, k;
      logic [15:0] t;

      rstb = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tgt_i[i] = 16'h0;
         vld[i]   = 1'b0;
         eni[i]   = 1'b1;
         mdl[i]   = 16'h8000;
      end
      #2;
      do_reset();

      vecs[0] = '{0, 16'h8000, 0, 1'b0, 0, 0};
      vecs[1] = '{0, 16'h8005, 0, 1'b0, 5, 5};
      vecs[2] = '{0, 16'h7FFE, 0, 1'b1, 7, 7};
      vecs[3] = '{1, 16'h8003, 2, 1'b0, 3, 14};
      vecs[4] = '{1, 16'h7FFF, 0, 1'b0, 4, 16};
      vecs[5] = '{0, 16'h7FFE, 0, 1'b0, 0, 0};
      vecs[6] = '{1, 16'h7FFF, 0, 1'b0, 0, 0};
      for (int i = 0; i < 7; i++) begin
         run_target(vecs[i].k, vecs[i].tgt, vecs[i].mode, vecs[i].hold, p, s);
         chk($sformatf("vec%0d_pulses", i), 32'(p), 32'(vecs[i].exp_pulses));
         chk($sformatf("vec%0d_settle", i), 32'(s), 32'(vecs[i].exp_settle));
      end

      // Reset while tracking toward 0x9000
      tgt_i[0] = 16'h9000;
      vld[0]   = 1'b1;
      step_cycle();
      vld[0] = 1'b0;
      repeat (10) step_cycle();
      chk("pre_reset_en", 32'(en_o[0]), 32'd1);
      chk("pre_reset_ready", 32'(rdy[0]), 32'd0);
      rstb = 1'b0;
      #1;
      chk("async_en", 32'(en_o[0]), 32'd0);
      chk("async_ready", 32'(rdy[0]), 32'd1);
      chk("async_settled", 32'(stl[0]), 32'd0);
      chk("async_shadow", 32'(shd[0]), 32'h8000);
      do_reset();
      chk("realign_shadow", 32'(shd[0]), 32'h8000);
      chk("realign_counter", 32'(cnt[0]), 32'h8000);

      // Randomized targets near the current position
      for (int i = 0; i < 16; i++) begin
         k   = i % 2;
         off = (k == 0) ? int'($urandom_range(0, 80)) - 40 : int'($urandom_range(0, 24)) - 12;
         v   = int'(mdl[k]) + off;
         if (v < 0) v = 0;
         if (v > 65535) v = 65535;
         t = 16'(v);
         n = (t > mdl[k]) ? int'(t) - int'(mdl[k]) : int'(mdl[k]) - int'(t);
         run_target(k, t, 1, 1'(i % 3 == 0), p, s);
         chk("rand_pulses", 32'(p), 32'(n));
      end

      // Upper boundary, then equal request at the top
      n = 65535 - int'(mdl[0]);
      run_target(0, 16'hFFFF, 0, 1'b0, p, s);
      chk("top_pulses", 32'(p), 32'(n));
      run_target(0, 16'hFFFF, 0, 1'b0, p, s);
      chk("top_again_pulses", 32'(p), 32'd0);
      chk("top_counter", 32'(cnt[0]), 32'hFFFF);

      // Lower boundary from the midpoint
      do_reset();
      run_target(0, 16'h0000, 0, 1'b0, p, s);
      chk("bottom_pulses", 32'(p), 32'd32768);
      run_target(0, 16'h0000, 0, 1'b0, p, s);
      chk("bottom_again_pulses", 32'(p), 32'd0);
      chk("bottom_shadow", 32'(shd[0]), 32'h0000);
      chk("bottom_counter", 32'(cnt[0]), 32'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/u_d_step_encoder.md
# u_d_step_encoder

Delta-step encoder driving the feedback up/down binary counter. Accepts a 16-bit target word over a valid/ready handshake. Emits one `u_d`/`en` step per tick until an internal shadow of the counter equals the target. The shadow resets to the same midpoint as the counter (0x8000), so a downstream counter clocked by `clk` and reset by the same `rstb` always holds the shadow value one cycle later.

## Interface
- `WIDTH`, 16: target, shadow and counter width.
- `RESET_VAL`, 1<<(WIDTH-1): shadow and target reset value; equals the counter reset value.
- `STEP_DIV`, 1: clocks per step tick (≥1). A value of 1 allows a step every clock.
- `clk` input 1: single clock. All state changes on its rising edge.
- `rstb` input 1: asynchronous, active-low reset.
- `target` input WIDTH: requested counter value. Sampled on accept.
- `target_valid` input 1: target is presented.
- `target_ready` output 1: encoder can accept a target.
- `en_in` input 1: global enable. When low, stepping freezes.
- `u_d` output 1: step direction to the counter. 1 = increment, 0 = decrement. Registered.
- `en` output 1: step strobe to the counter. High for one cycle per step. Registered.
- `shadow` output WIDTH: encoder's copy of the counter value after all issued steps.
- `settled` output 1: shadow equals the last accepted target.

## Operation
- **Reset values:** state IDLE, `shadow`=`RESET_VAL`, target register=`RESET_VAL`, `u_d`=0, `en`=0, `settled`=0, `target_ready`=1, divider=0.
- **States:**
  - **IDLE:** no target accepted yet since reset.
  - **TRACK:** steps are issued toward the target.
  - **SETTLED:** `shadow` equals the target.
- **target_ready:** 1 in IDLE and SETTLED, 0 in TRACK. A new target cannot interrupt tracking.
- **Accept:** occurs on an edge where `target_valid & target_ready`. The target register loads, and the divider clears.
  - Next state is SETTLED if `target`==`shadow`, else TRACK.
  - Accept is independent of `en_in`.
- **Divider:** counts 0..`STEP_DIV`-1 while in TRACK with `en_in`=1, and holds its value while `en_in`=0. The tick condition is divider==`STEP_DIV`-1; for `STEP_DIV`=1 every cycle ticks.
- **Step:** in TRACK, on a tick edge with `en_in`=1 and `shadow`≠target:
  - Set `en`=1 and `u_d`=(target>`shadow`).
  - Update `shadow` ±1 on the same edge.
  - On every edge with no step, `en`=0. `u_d` holds its last value.
- **Completion:** on the edge where the stepped `shadow` equals the target, state goes to SETTLED and `settled` goes to 1.
- **Leaving SETTLED:** `settled` goes to 0 on the edge a differing target is accepted. Accepting an equal target keeps `settled`=1 and issues no step.
- **Range:** comparison is unsigned. `shadow` never wraps: a step is issued only toward a target inside [0, 2^WIDTH-1], so 0x0000 and 0xFFFF are reachable and never crossed.
- **Reset mid-TRACK:** all registers return to their reset values immediately, and `en` drops asynchronously. Encoder and counter re-align at `RESET_VAL`.
- **Divergence:** `shadow` is not fed back from the counter. The counter's `en` input must be driven only by this block.

## Timing
- **Accept to first step:** accept at edge A. First `en`=1 is registered at edge A+`STEP_DIV`, and the counter applies it at edge A+`STEP_DIV`+1.
- **Step count:** a distance of N issues exactly N `en` pulses, spaced `STEP_DIV` cycles apart when `en_in` stays high.
- **Settle time:** `settled` rises at edge A+N·`STEP_DIV`. The counter reaches the target one edge later.
- **en_in low:** suppresses the step on that edge and adds exactly one cycle per low cycle to the settle time, because the divider holds.
- **Back-to-back accepts:** a new target may be accepted on the same edge `settled` rose? No. `target_ready` is registered from state, so the earliest next accept is the edge after SETTLED is entered.

## Test plan
- **Reset:** assert `rstb` low for 3 cycles -> `shadow`=0x8000, `en`=0, `settled`=0, `target_ready`=1. A counter model holds 0x8000.
- **Up then down:** target 0x8005 with `STEP_DIV`=1 -> 5 consecutive `en` pulses with `u_d`=1, `settled` at A+5, counter=0x8005. Then target 0x7FFE -> 7 pulses with `u_d`=0, counter=0x7FFE.
- **Divider and enable:** `STEP_DIV`=4, target 0x8003 -> pulses at A+4, A+8, A+12. Drop `en_in` for 2 cycles mid-track -> last pulse moves to A+14 and the pulse count stays 3.
- **Equal target and ready:** target 0x8000 right after reset -> no `en` pulse, `settled`=1 after one edge. `target_valid` held during TRACK -> not accepted until SETTLED.
- **Boundaries:** track to 0xFFFF, then request 0xFFFF again -> no pulse and no wrap. Track to 0x0000 -> counter=0x0000 and `shadow` never wraps to 0xFFFF.
- **Reset mid-track:** assert `rstb` low during TRACK toward 0x9000 -> `en` low immediately and state IDLE. After release, `shadow`=counter=0x8000.
